pcs_tx_sched: RTL

//  TX frame scheduler in front of pcs_enc_lite, 10G, 64-bit datapath, one 66b block per cycle.

---
 rtl/pcs_pkg.sv | 57 +++++
 rtl/pcs_tx_sched_if.sv | 24 ++
 rtl/pcs_tx_blk_mux.sv | 48 ++++
 rtl/pcs_tx_sched.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS TX definitions: 66b block-type codes, control characters, scheduler types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcs_pkg;

    // 66b block-type field values (sync header 10)
    localparam logic [7:0] BLOCK_TYPE_CTRL  = 8'h1E;
    localparam logic [7:0] BLOCK_TYPE_START = 8'h78;
    localparam logic [7:0] BLOCK_TYPE_TERM0 = 8'h87;
    localparam logic [7:0] BLOCK_TYPE_TERM1 = 8'h99;
    localparam logic [7:0] BLOCK_TYPE_TERM2 = 8'hAA;
    localparam logic [7:0] BLOCK_TYPE_TERM3 = 8'hB4;
    localparam logic [7:0] BLOCK_TYPE_TERM4 = 8'hCC;
    localparam logic [7:0] BLOCK_TYPE_TERM5 = 8'hD2;
    localparam logic [7:0] BLOCK_TYPE_TERM6 = 8'hE1;
    localparam logic [7:0] BLOCK_TYPE_TERM7 = 8'hFF;

    localparam logic [6:0] CTRL_IDLE = 7'h00;
    localparam logic [6:0] CTRL_ERR  = 7'h1E;

    // D1..D7 of a start block, D7 being the SFD
    localparam logic [55:0] PREAMBLE_SFD = 56'hD5555555555555;

    // Each state names the block produced on the next downstream-ready cycle
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TERM0
    } pcs_tx_state_e;

    typedef enum logic [2:0] {
        BLK_IDLE,
        BLK_START,
        BLK_DATA,
        BLK_TERM,
        BLK_ERR
    } pcs_blk_kind_e;

    // Encoder control fields for one block
    typedef struct packed {
        logic        ctrl_v;
        logic        idle_v;
        logic [1:0]  start_v;
        logic        term_v;
        logic        err_v;
        logic [63:0] data;
        logic [7:0]  keep;
    } pcs_enc_blk_t;

    localparam pcs_enc_blk_t ENC_IDLE_BLK = {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 64'h0, 8'h00};

    // True for a legal partial last beat: 1..7 bytes, contiguous from byte 0
    function automatic logic keep_is_partial(input logic [7:0] keep);
        return keep inside {8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F};
    endfunction

endpackage

// File: rtl/pcs_tx_sched_if.sv
// MAC-side frame stream into the TX scheduler.
// Latency: n/a (wires only).
// Backpressure: beat transfers when s_valid_i & s_ready_o.
interface pcs_tx_sched_if #(
    parameter int DATA_W = 64
);
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_W-1:0]     s_data_i;
    logic [DATA_W/8-1:0]   s_keep_i;
    logic                  s_last_i;

    // MAC side drives beats
    modport master (
        output s_valid_i, s_data_i, s_keep_i, s_last_i,
        input  s_ready_o
    );

    // Scheduler side accepts beats
    modport slave (
        input  s_valid_i, s_data_i, s_keep_i, s_last_i,
        output s_ready_o
    );
endinterface

// File: rtl/pcs_tx_blk_mux.sv
// Maps a block kind plus the current beat onto pcs_enc_lite control/data fields.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module pcs_tx_blk_mux
    import pcs_pkg::*;
#(
    parameter logic [55:0] PREAMBLE = PREAMBLE_SFD
) (
    input  pcs_blk_kind_e kind,
    input  logic [63:0]   beat_data,
    input  logic [7:0]    beat_keep,
    output pcs_enc_blk_t  blk
);

    // Idle block is the default; each kind overrides only its own fields
    always_comb begin
        blk        = '0;
        blk.ctrl_v = 1'b1;
        blk.idle_v = 1'b1;
        blk.data   = {8{1'b0, CTRL_IDLE}};
        case (kind)
            BLK_START: begin
                blk.idle_v  = 1'b0;
                blk.start_v = 2'b01;
                blk.data    = {PREAMBLE, 8'h00};
            end
            BLK_DATA: begin
                blk.ctrl_v = 1'b0;
                blk.idle_v = 1'b0;
                blk.data   = beat_data;
                blk.keep   = 8'hFF;
            end
            BLK_TERM: begin
                blk.idle_v = 1'b0;
                blk.term_v = 1'b1;
                blk.data   = {beat_data[55:0], 8'h00};
                blk.keep   = beat_keep;
            end
            BLK_ERR: begin
                blk.idle_v = 1'b0;
                blk.err_v  = 1'b1;
                blk.data   = {8{1'b0, CTRL_ERR}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pcs_tx_sched.sv
// TX frame scheduler: MAC beats -> one idle/start/data/term/err block per ready cycle. Optional stats: PCS_TX_SCHED_STATS_EN.
// Latency: accepted beat reaches the encoder inputs 1 cycle later; start and TERM_0 each add one block.
// Backpressure: pcs_ready_i=0 freezes state and outputs; s_ready_o is high only in DATA with pcs_ready_i.
module pcs_tx_sched
    import pcs_pkg::*;
#(
    parameter int          DATA_W     = 64,
    parameter int          KEEP_W     = DATA_W / 8,
    parameter int          IPG_BLOCKS = 1,
    parameter logic [55:0] PREAMBLE   = PREAMBLE_SFD
`ifdef PCS_TX_SCHED_STATS_EN
    ,
    parameter int          STATS_W    = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    pcs_tx_sched_if.slave     s,
    input  logic              pcs_ready_i,
    output logic              ctrl_v_o,
    output logic              idle_v_o,
    output logic [1:0]        start_v_o,
    output logic              term_v_o,
    output logic              err_v_o,
    output logic [DATA_W-1:0] data_o,
    output logic [KEEP_W-1:0] keep_o,
    output logic              part_o,
    output logic              underrun_o
`ifdef PCS_TX_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] frame_cnt_o,
    output logic [STATS_W-1:0] underrun_cnt_o
`endif
);

    // ipg_cnt holds the idle blocks still owed before a start may go out;
    // loading the full gap after term/err yields exactly IPG_BLOCKS idles.
    localparam logic [3:0] IPG_INIT = 4'(IPG_BLOCKS);

    pcs_tx_state_e state_q, state_d;
    logic [3:0]    ipg_q, ipg_d;
    pcs_blk_kind_e kind;
    logic [63:0]   beat_data;
    logic [7:0]    beat_keep;
    pcs_enc_blk_t  blk_d, blk_q;
    logic          underrun_q;

    assign s.s_ready_o = pcs_ready_i & (state_q == DATA);

    // Next state, gap counter and kind of the block to emit next
    always_comb begin
        state_d   = state_q;
        ipg_d     = ipg_q;
        kind      = BLK_IDLE;
        beat_data = s.s_data_i;
        beat_keep = s.s_keep_i;
        case (state_q)
            IDLE: begin
                if (s.s_valid_i && (ipg_q == 4'd0)) begin
                    kind    = BLK_START;
                    state_d = DATA;
                end else if (ipg_q != 4'd0) begin
                    ipg_d = ipg_q - 4'd1;
                end
            end
            DATA: begin
                if (!s.s_valid_i) begin
                    // Underrun: abort the frame; the rest restarts as a new frame
                    kind    = BLK_ERR;
                    ipg_d   = IPG_INIT;
                    state_d = IDLE;
                end else if (!s.s_last_i) begin
                    kind = BLK_DATA;
                end else if (keep_is_partial(s.s_keep_i)) begin
                    kind    = BLK_TERM;
                    ipg_d   = IPG_INIT;
                    state_d = IDLE;
                end else begin
                    // Full last beat (illegal keep included) needs a separate TERM_0
                    kind    = BLK_DATA;
                    state_d = TERM0;
                end
            end
            TERM0: begin
                kind      = BLK_TERM;
                beat_data = '0;
                beat_keep = '0;
                ipg_d     = IPG_INIT;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    pcs_tx_blk_mux #(
        .PREAMBLE (PREAMBLE)
    ) u_blk_mux (
        .kind      (kind),
        .beat_data (beat_data),
        .beat_keep (beat_keep),
        .blk       (blk_d)
    );

    // State and output block advance only when the gearbox takes a block
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ipg_q      <= IPG_INIT;
            blk_q      <= ENC_IDLE_BLK;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= pcs_ready_i && (kind == BLK_ERR);
            if (pcs_ready_i) begin
                state_q <= state_d;
                ipg_q   <= ipg_d;
                blk_q   <= blk_d;
            end
        end
    end

    assign ctrl_v_o   = blk_q.ctrl_v;
    assign idle_v_o   = blk_q.idle_v;
    assign start_v_o  = blk_q.start_v;
    assign term_v_o   = blk_q.term_v;
    assign err_v_o    = blk_q.err_v;
    assign data_o     = blk_q.data;
    assign keep_o     = blk_q.keep;
    assign part_o     = 1'b0;
    assign underrun_o = underrun_q;

`ifdef PCS_TX_SCHED_STATS_EN
    logic [STATS_W-1:0] frame_cnt_q, underrun_cnt_q;

    // Free-running wrap-around counters of emitted term and err blocks
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q    <= '0;
            underrun_cnt_q <= '0;
        end else if (pcs_ready_i) begin
            if (kind == BLK_TERM) frame_cnt_q    <= frame_cnt_q + 1'b1;
            if (kind == BLK_ERR)  underrun_cnt_q <= underrun_cnt_q + 1'b1;
        end
    end

    assign frame_cnt_o    = frame_cnt_q;
    assign underrun_cnt_o = underrun_cnt_q;
`endif

`ifdef FORMAL
    // A last beat should carry keep FF or a contiguous partial mask
    always_ff @(posedge clk) begin
        if (!reset && s.s_valid_i && s.s_ready_o && s.s_last_i)
            assert (keep_is_partial(s.s_keep_i) || (s.s_keep_i == 8'hFF));
    end
`endif

endmodule
